// File: rtl/graphics_command_decoder.sv
`default_nettype none
// ============================================================================
// Module  : graphics_command_decoder
// Purpose : SPI op-code/operand stream -> pallet writes, pixel spans, buffer switch
// Revision: 1.0
// ============================================================================
module graphics_command_decoder #(
    parameter int PIXEL_ADDRESS_WIDTH = 18,
    parameter int COLOR_INDEX_WIDTH   = 4,
    parameter int Y_WIDTH             = 4,
    parameter int CB_WIDTH            = 3,
    parameter int CR_WIDTH            = 3
) (
    input  logic                                      clock_in,
    input  logic                                      reset_n_in,
    input  logic [7:0]                                op_code_in,
    input  logic                                      op_code_valid_in,
    input  logic [7:0]                                operand_in,
    input  logic                                      operand_valid_in,
    input  logic [31:0]                               operand_count_in,
    output logic                                      pallet_assign_enable_out,
    output logic [COLOR_INDEX_WIDTH-1:0]              pallet_assign_index_out,
    output logic [Y_WIDTH+CB_WIDTH+CR_WIDTH-1:0]      pallet_assign_value_out,
    output logic                                      pixel_write_enable_out,
    output logic [PIXEL_ADDRESS_WIDTH-1:0]            pixel_write_address_out,
    output logic [COLOR_INDEX_WIDTH-1:0]              pixel_write_data_out,
    input  logic                                      pixel_write_ready_in,
    output logic                                      switch_buffer_out,
    output logic                                      busy_out,
    output logic                                      overflow_out
);

    localparam int          N_ADDR      = (PIXEL_ADDRESS_WIDTH + 7) / 8;
    localparam int          VALUE_WIDTH = Y_WIDTH + CB_WIDTH + CR_WIDTH;
    localparam logic [7:0]  OP_ASSIGN   = 8'h10;
    localparam logic [7:0]  OP_SHOW     = 8'h17;
    localparam logic [7:0]  OP_DRAW     = 8'h19;
    localparam logic [7:0]  OP_FILL     = 8'h1A;
    localparam logic [31:0] CNT_ADDR    = 32'(N_ADDR);
    localparam logic [31:0] CNT_COLOR   = 32'(N_ADDR + 1);
    localparam logic [31:0] CNT_LEN     = 32'(N_ADDR + 2);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t                           state_q, state_d;
    logic [PIXEL_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [COLOR_INDEX_WIDTH-1:0]     data_q, data_d;
    logic [7:0]                       remaining_q, remaining_d;
    logic                             seq_ok_q, seq_ok_d;
    logic                             show_seen_q, show_seen_d;
    logic [PIXEL_ADDRESS_WIDTH-1:0]   addr_sh_q, addr_sh_d;
    logic [COLOR_INDEX_WIDTH-1:0]     color_sh_q, color_sh_d;
    logic [COLOR_INDEX_WIDTH-1:0]     index_sh_q, index_sh_d;
    logic [Y_WIDTH-1:0]               y_sh_q, y_sh_d;
    logic [CB_WIDTH-1:0]              cb_sh_q, cb_sh_d;
    logic                             pal_en_q, pal_en_d;
    logic [COLOR_INDEX_WIDTH-1:0]     pal_index_q, pal_index_d;
    logic [VALUE_WIDTH-1:0]           pal_value_q, pal_value_d;
    logic                             switch_q, switch_d;
    logic                             pending_q, pending_d;
    logic                             busy_q, busy_d;
    logic                             overflow_q, overflow_d;

    logic                             beat;
    logic                             show_req;
    logic                             launch;
    logic [COLOR_INDEX_WIDTH-1:0]     launch_data;
    logic [7:0]                       launch_len;
    logic                             span_done;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        seq_ok_d    = seq_ok_q;
        show_seen_d = show_seen_q;
        addr_sh_d   = addr_sh_q;
        color_sh_d  = color_sh_q;
        index_sh_d  = index_sh_q;
        y_sh_d      = y_sh_q;
        cb_sh_d     = cb_sh_q;
        pal_en_d    = 1'b0;
        pal_index_d = pal_index_q;
        pal_value_d = pal_value_q;
        switch_d    = 1'b0;
        pending_d   = pending_q;
        overflow_d  = overflow_q;
        launch      = 1'b0;
        launch_data = color_sh_q;
        launch_len  = 8'd0;

        beat      = op_code_valid_in && operand_valid_in;
        show_req  = op_code_valid_in && (op_code_in == OP_SHOW) && !show_seen_q;
        span_done = (state_q == ST_WRITE) && pixel_write_ready_in && (remaining_q == 8'd1);

        // A command is only completed if its first operand was seen while
        // op_code_valid_in stayed high throughout.
        if (!op_code_valid_in) begin
            seq_ok_d    = 1'b0;
            show_seen_d = 1'b0;
        end else begin
            if (beat && operand_count_in == 32'd1) seq_ok_d = 1'b1;
            if (op_code_in == OP_SHOW) show_seen_d = 1'b1;
        end

        if (beat) begin
            case (op_code_in)
                OP_ASSIGN: begin
                    if (operand_count_in == 32'd1) begin
                        index_sh_d = operand_in[COLOR_INDEX_WIDTH-1:0];
                    end else if (operand_count_in == 32'd2) begin
                        y_sh_d = operand_in[7 -: Y_WIDTH];
                    end else if (operand_count_in == 32'd3) begin
                        cb_sh_d = operand_in[7 -: CB_WIDTH];
                    end else if (operand_count_in == 32'd4 && seq_ok_q) begin
                        pal_en_d    = 1'b1;
                        pal_index_d = index_sh_q;
                        pal_value_d = {y_sh_q, cb_sh_q, operand_in[7 -: CR_WIDTH]};
                    end
                end
                OP_DRAW, OP_FILL: begin
                    // Address bytes arrive MSB first; truncation drops bits above the width.
                    if (operand_count_in == 32'd1) begin
                        addr_sh_d = PIXEL_ADDRESS_WIDTH'(operand_in);
                    end else if (operand_count_in <= CNT_ADDR) begin
                        addr_sh_d = PIXEL_ADDRESS_WIDTH'({addr_sh_q, operand_in});
                    end else if (operand_count_in == CNT_COLOR) begin
                        color_sh_d = operand_in[COLOR_INDEX_WIDTH-1:0];
                        if (op_code_in == OP_DRAW && seq_ok_q) begin
                            launch      = 1'b1;
                            launch_data = operand_in[COLOR_INDEX_WIDTH-1:0];
                            launch_len  = 8'd1;
                        end
                    end else if (operand_count_in == CNT_LEN && op_code_in == OP_FILL && seq_ok_q) begin
                        launch     = 1'b1;
                        launch_len = operand_in;
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_WRITE: begin
                if (pixel_write_ready_in) begin
                    addr_d      = addr_q + PIXEL_ADDRESS_WIDTH'(1);
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (launch && launch_len != 8'd0) begin
            if (state_q == ST_IDLE && !pending_q) begin
                state_d     = ST_WRITE;
                addr_d      = addr_sh_q;
                data_d      = launch_data;
                remaining_d = launch_len;
            end else begin
                overflow_d = 1'b1;
            end
        end

        // Switch fires as soon as no span is outstanding; repeat requests merge.
        if (show_req || pending_q) begin
            if (state_q == ST_IDLE || span_done) begin
                switch_d  = 1'b1;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end

        busy_d = (state_d == ST_WRITE) || pending_d;
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            remaining_q <= '0;
            seq_ok_q    <= 1'b0;
            show_seen_q <= 1'b0;
            addr_sh_q   <= '0;
            color_sh_q  <= '0;
            index_sh_q  <= '0;
            y_sh_q      <= '0;
            cb_sh_q     <= '0;
            pal_en_q    <= 1'b0;
            pal_index_q <= '0;
            pal_value_q <= '0;
            switch_q    <= 1'b0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            seq_ok_q    <= seq_ok_d;
            show_seen_q <= show_seen_d;
            addr_sh_q   <= addr_sh_d;
            color_sh_q  <= color_sh_d;
            index_sh_q  <= index_sh_d;
            y_sh_q      <= y_sh_d;
            cb_sh_q     <= cb_sh_d;
            pal_en_q    <= pal_en_d;
            pal_index_q <= pal_index_d;
            pal_value_q <= pal_value_d;
            switch_q    <= switch_d;
            pending_q   <= pending_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pallet_assign_enable_out = pal_en_q;
    assign pallet_assign_index_out  = pal_index_q;
    assign pallet_assign_value_out  = pal_value_q;
    assign pixel_write_enable_out   = (state_q == ST_WRITE);
    assign pixel_write_address_out  = addr_q;
    assign pixel_write_data_out     = data_q;
    assign switch_buffer_out        = switch_q;
    assign busy_out                 = busy_q;
    assign overflow_out             = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_graphics_command_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_graphics_command_decoder
// Purpose : scenario tasks plus randomized commands against a span/pallet model
// Revision: 1.0
// ============================================================================
module tb_graphics_command_decoder;

    localparam int AW   = 18;
    localparam int AMOD = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  op_code_in;
    logic        op_code_valid_in;
    logic [7:0]  operand_in;
    logic        operand_valid_in;
    logic [31:0] operand_count_in;
    logic        pallet_assign_enable_out;
    logic [3:0]  pallet_assign_index_out;
    logic [9:0]  pallet_assign_value_out;
    logic        pixel_write_enable_out;
    logic [17:0] pixel_write_address_out;
    logic [3:0]  pixel_write_data_out;
    logic        pixel_write_ready_in;
    logic        switch_buffer_out;
    logic        busy_out;
    logic        overflow_out;

    graphics_command_decoder dut (
        .clock_in                 (clk),
        .reset_n_in               (rst_n),
        .op_code_in               (op_code_in),
        .op_code_valid_in         (op_code_valid_in),
        .operand_in               (operand_in),
        .operand_valid_in         (operand_valid_in),
        .operand_count_in         (operand_count_in),
        .pallet_assign_enable_out (pallet_assign_enable_out),
        .pallet_assign_index_out  (pallet_assign_index_out),
        .pallet_assign_value_out  (pallet_assign_value_out),
        .pixel_write_enable_out   (pixel_write_enable_out),
        .pixel_write_address_out  (pixel_write_address_out),
        .pixel_write_data_out     (pixel_write_data_out),
        .pixel_write_ready_in     (pixel_write_ready_in),
        .switch_buffer_out        (switch_buffer_out),
        .busy_out                 (busy_out),
        .overflow_out             (overflow_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_op_cyc;
    int req_cyc;
    bit rand_ready = 1'b0;
    logic [7:0] cmd_b [0:7];

    // observation log, filled on the falling edge
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int pal_idx[$];
    int pal_val[$];
    int pal_cyc[$];
    int sw_cyc[$];
    int en_cnt;
    int busy_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pixel_write_enable_out) en_cnt++;
            if (busy_out) busy_cnt++;
            if (pixel_write_enable_out && pixel_write_ready_in) begin
                wr_addr.push_back(int'(pixel_write_address_out));
                wr_data.push_back(int'(pixel_write_data_out));
                wr_cyc.push_back(cyc);
            end
            if (pallet_assign_enable_out) begin
                pal_idx.push_back(int'(pallet_assign_index_out));
                pal_val.push_back(int'(pallet_assign_value_out));
                pal_cyc.push_back(cyc);
            end
            if (switch_buffer_out) sw_cyc.push_back(cyc);
        end
    end

    task automatic clear_obs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        pal_idx.delete(); pal_val.delete(); pal_cyc.delete();
        sw_cyc.delete();
        en_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) pixel_write_ready_in = ($urandom_range(0, 3) != 0);
    endtask

    // n_send < n_ops drops op_code_valid_in early (partial command)
    task automatic send_cmd(input logic [7:0] op, input int n_send, input int gap_max);
        op_code_in       = op;
        op_code_valid_in = 1'b1;
        for (int i = 0; i < n_send; i++) begin
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(0, gap_max);
                operand_valid_in = 1'b0;
                repeat (g) tick();
            end
            operand_in       = cmd_b[i];
            operand_count_in = 32'(i + 1);
            operand_valid_in = 1'b1;
            tick();
        end
        last_op_cyc      = cyc;
        operand_valid_in = 1'b0;
        op_code_valid_in = 1'b0;
    endtask

    task automatic send_show(input int hold);
        op_code_in       = 8'h17;
        op_code_valid_in = 1'b1;
        operand_valid_in = 1'b0;
        tick();
        req_cyc = cyc;
        repeat (hold - 1) tick();
        op_code_valid_in = 1'b0;
        tick();
    endtask

    task automatic set_pixel_cmd(input int addr, input int color, input int len);
        cmd_b[0] = 8'((addr >> 16) & 8'hFF);
        cmd_b[1] = 8'((addr >> 8) & 8'hFF);
        cmd_b[2] = 8'(addr & 8'hFF);
        cmd_b[3] = 8'(color);
        cmd_b[4] = 8'(len);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy_out || pixel_write_enable_out) && k < 300) begin
            tick();
            k++;
        end
        total++;
        if (busy_out || pixel_write_enable_out) begin
            bad++;
            $display("FAIL %s_timeout: busy=%0b enable=%0b, want both 0 within 300 cycles", name, busy_out, pixel_write_enable_out);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({pallet_assign_enable_out, pixel_write_enable_out, switch_buffer_out, busy_out, overflow_out} !== 5'b0) begin
            bad++;
            $display("FAIL reset_strobes: got %b want 00000", {pallet_assign_enable_out, pixel_write_enable_out, switch_buffer_out, busy_out, overflow_out});
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({pallet_assign_index_out, pallet_assign_value_out, pixel_write_address_out, pixel_write_data_out} !== 36'b0) begin
            bad++;
            $display("FAIL reset_data: idx=%h val=%h addr=%h data=%h want all 0", pallet_assign_index_out, pallet_assign_value_out, pixel_write_address_out, pixel_write_data_out);
        end
        total++;
        if ({pixel_write_enable_out, busy_out, overflow_out} !== 3'b0) begin
            bad++;
            $display("FAIL reset_release: en/busy/ovf=%b want 000", {pixel_write_enable_out, busy_out, overflow_out});
        end
    endtask

    task automatic test_assign();
        int exp_val;
        clear_obs();
        cmd_b[0] = 8'h05; cmd_b[1] = 8'hA0; cmd_b[2] = 8'h60; cmd_b[3] = 8'hE0;
        send_cmd(8'h10, 4, 0);
        tick(); tick();
        exp_val = ((8'hA0 >> 4) << 6) | ((8'h60 >> 5) << 3) | (8'hE0 >> 5);
        total++;
        if (pal_idx.size() != 1) begin
            bad++;
            $display("FAIL assign_pulses: got %0d want 1", pal_idx.size());
        end else begin
            total++;
            if (pal_idx[0] !== 5 || pal_val[0] !== exp_val || exp_val !== 'h29F) begin
                bad++;
                $display("FAIL assign_value: idx=%0d val=%h want idx=5 val=29f", pal_idx[0], pal_val[0]);
            end
            total++;
            if (pal_cyc[0] !== last_op_cyc) begin
                bad++;
                $display("FAIL assign_latency: pulse cycle %0d want %0d", pal_cyc[0], last_op_cyc);
            end
        end
    endtask

    task automatic test_draw();
        clear_obs();
        pixel_write_ready_in = 1'b1;
        cmd_b[0] = 8'h01; cmd_b[1] = 8'h23; cmd_b[2] = 8'h45; cmd_b[3] = 8'h0C;
        send_cmd(8'h19, 4, 0);
        wait_idle("draw");
        total++;
        if (wr_addr.size() != 1 || en_cnt != 1) begin
            bad++;
            $display("FAIL draw_count: writes=%0d enable_cycles=%0d want 1 and 1", wr_addr.size(), en_cnt);
        end else begin
            total++;
            if (wr_addr[0] !== 'h12345 || wr_data[0] !== 'hC) begin
                bad++;
                $display("FAIL draw_write: addr=%h data=%h want 12345 c", wr_addr[0], wr_data[0]);
            end
            total++;
            if (wr_cyc[0] !== last_op_cyc) begin
                bad++;
                $display("FAIL draw_latency: write cycle %0d want %0d", wr_cyc[0], last_op_cyc);
            end
        end
    endtask

    task automatic test_fill_wrap();
        clear_obs();
        pixel_write_ready_in = 1'b1;
        set_pixel_cmd('h3FFFE, 3, 4);
        send_cmd(8'h1A, 5, 0);
        tick();
        pixel_write_ready_in = 1'b0;
        total++;
        if (!pixel_write_enable_out || pixel_write_address_out !== 18'h3FFFF) begin
            bad++;
            $display("FAIL fill_stall_a: en=%0b addr=%h want 1 3ffff", pixel_write_enable_out, pixel_write_address_out);
        end
        tick();
        total++;
        if (!pixel_write_enable_out || pixel_write_address_out !== 18'h3FFFF) begin
            bad++;
            $display("FAIL fill_stall_hold: en=%0b addr=%h want 1 3ffff", pixel_write_enable_out, pixel_write_address_out);
        end
        pixel_write_ready_in = 1'b1;
        wait_idle("fill");
        total++;
        if (wr_addr.size() != 4 || en_cnt != 5) begin
            bad++;
            $display("FAIL fill_count: writes=%0d enable_cycles=%0d want 4 and 5", wr_addr.size(), en_cnt);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (wr_addr[i] !== ('h3FFFE + i) % AMOD || wr_data[i] !== 3) begin
                    bad++;
                    $display("FAIL fill_write%0d: addr=%h data=%0d want %h 3", i, wr_addr[i], wr_data[i], ('h3FFFE + i) % AMOD);
                end
            end
        end
    endtask

    // span of len with one or two show commands issued while it runs
    task automatic show_during_span(input string name, input int len, input int n_show, input int hold);
        int k;
        clear_obs();
        pixel_write_ready_in = 1'b1;
        set_pixel_cmd('h00100, 7, len);
        send_cmd(8'h1A, 5, 0);
        for (int s = 0; s < n_show; s++) send_show(hold);
        k = 0;
        while (!switch_buffer_out && k < 50) begin
            tick();
            k++;
        end
        tick();
        total++;
        if (busy_out !== 1'b0 || switch_buffer_out !== 1'b0) begin
            bad++;
            $display("FAIL %s_after: busy=%0b switch=%0b want 0 0", name, busy_out, switch_buffer_out);
        end
        wait_idle(name);
        total++;
        if (sw_cyc.size() != 1 || wr_cyc.size() != len) begin
            bad++;
            $display("FAIL %s_pulses: switch=%0d writes=%0d want 1 and %0d", name, sw_cyc.size(), wr_cyc.size(), len);
        end else begin
            total++;
            if (sw_cyc[0] !== wr_cyc[len - 1] + 1) begin
                bad++;
                $display("FAIL %s_timing: switch cycle %0d want %0d", name, sw_cyc[0], wr_cyc[len - 1] + 1);
            end
        end
    endtask

    task automatic test_show();
        clear_obs();
        send_show(1);
        tick();
        total++;
        if (sw_cyc.size() != 1 || busy_cnt != 0) begin
            bad++;
            $display("FAIL show_idle: pulses=%0d busy_cycles=%0d want 1 0", sw_cyc.size(), busy_cnt);
        end else begin
            total++;
            if (sw_cyc[0] !== req_cyc) begin
                bad++;
                $display("FAIL show_idle_latency: cycle %0d want %0d", sw_cyc[0], req_cyc);
            end
        end
        show_during_span("show_l3", 3, 1, 2);
        show_during_span("show_merge", 6, 2, 1);
    endtask

    task automatic test_zero_len();
        clear_obs();
        pixel_write_ready_in = 1'b1;
        set_pixel_cmd('h00200, 1, 0);
        send_cmd(8'h1A, 5, 0);
        repeat (5) tick();
        total++;
        if (en_cnt != 0 || busy_cnt != 0 || wr_addr.size() != 0 || overflow_out !== 1'b0) begin
            bad++;
            $display("FAIL zero_len: enable=%0d busy=%0d writes=%0d ovf=%0b want 0 0 0 0", en_cnt, busy_cnt, wr_addr.size(), overflow_out);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        pixel_write_ready_in = 1'b0;
        set_pixel_cmd('h01111, 2, 1);
        send_cmd(8'h19, 4, 0);
        set_pixel_cmd('h02222, 5, 1);
        send_cmd(8'h19, 4, 0);
        total++;
        if (overflow_out !== 1'b1) begin
            bad++;
            $display("FAIL b2b_overflow: got %0b want 1", overflow_out);
        end
        pixel_write_ready_in = 1'b1;
        wait_idle("b2b");
        total++;
        if (wr_addr.size() != 1) begin
            bad++;
            $display("FAIL b2b_count: writes=%0d want 1", wr_addr.size());
        end else begin
            total++;
            if (wr_addr[0] !== 'h01111 || wr_data[0] !== 2) begin
                bad++;
                $display("FAIL b2b_write: addr=%h data=%0d want 01111 2", wr_addr[0], wr_data[0]);
            end
        end
        cmd_b[0] = 8'h05; cmd_b[1] = 8'hA0; cmd_b[2] = 8'h60; cmd_b[3] = 8'hE0;
        send_cmd(8'h10, 2, 0);
        repeat (4) tick();
        total++;
        if (pal_idx.size() != 0 || overflow_out !== 1'b1) begin
            bad++;
            $display("FAIL partial_assign: pulses=%0d ovf=%0b want 0 1", pal_idx.size(), overflow_out);
        end
    endtask

    task automatic test_random();
        int exp_addr[$];
        int exp_data[$];
        int exp_idx[$];
        int exp_val[$];
        int kind, a, c, len;
        rand_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            clear_obs();
            exp_addr.delete(); exp_data.delete(); exp_idx.delete(); exp_val.delete();
            for (int i = 0; i < 8; i++) cmd_b[i] = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 3);
            a = ($urandom_range(0, 3) == 0) ? AMOD - $urandom_range(1, 3) : $urandom_range(0, AMOD - 1);
            if (kind == 0) begin
                exp_idx.push_back(cmd_b[0] % 16);
                exp_val.push_back(((cmd_b[1] / 16) * 64) + ((cmd_b[2] / 32) * 8) + (cmd_b[3] / 32));
                send_cmd(8'h10, 4, 2);
            end else if (kind == 3) begin
                send_cmd(8'h11, 6, 2);
            end else begin
                c = $urandom_range(0, 255);
                len = (kind == 1) ? 1 : $urandom_range(0, 6);
                set_pixel_cmd(a, c, len);
                cmd_b[0] = cmd_b[0] | 8'($urandom_range(0, 63) << 2);
                a = ((int'(cmd_b[0]) << 16) + (int'(cmd_b[1]) << 8) + int'(cmd_b[2])) % AMOD;
                for (int i = 0; i < len; i++) begin
                    exp_addr.push_back((a + i) % AMOD);
                    exp_data.push_back(c % 16);
                end
                send_cmd((kind == 1) ? 8'h19 : 8'h1A, (kind == 1) ? 4 : 5, 2);
            end
            wait_idle("rand");
            total++;
            if (wr_addr.size() != exp_addr.size() || pal_idx.size() != exp_idx.size()) begin
                bad++;
                $display("FAIL rand%0d_counts: writes=%0d pallet=%0d want %0d %0d", n, wr_addr.size(), pal_idx.size(), exp_addr.size(), exp_idx.size());
            end else begin
                foreach (exp_addr[i]) begin
                    total++;
                    if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                        bad++;
                        $display("FAIL rand%0d_write%0d: addr=%h data=%0d want %h %0d", n, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
                    end
                end
                foreach (exp_idx[i]) begin
                    total++;
                    if (pal_idx[i] !== exp_idx[i] || pal_val[i] !== exp_val[i]) begin
                        bad++;
                        $display("FAIL rand%0d_pallet: idx=%0d val=%h want %0d %h", n, pal_idx[i], pal_val[i], exp_idx[i], exp_val[i]);
                    end
                end
            end
        end
        rand_ready = 1'b0;
    endtask

    task automatic test_reset_mid_span();
        clear_obs();
        pixel_write_ready_in = 1'b0;
        set_pixel_cmd('h0ABCD, 9, 5);
        send_cmd(8'h1A, 5, 0);
        total++;
        if (!pixel_write_enable_out) begin
            bad++;
            $display("FAIL rst_span_start: enable=%0b want 1", pixel_write_enable_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({pixel_write_enable_out, busy_out, overflow_out, switch_buffer_out, pallet_assign_enable_out} !== 5'b0 ||
            pixel_write_address_out !== 18'h0 || pixel_write_data_out !== 4'h0) begin
            bad++;
            $display("FAIL rst_mid_span: en=%0b busy=%0b ovf=%0b addr=%h data=%h want all 0", pixel_write_enable_out, busy_out, overflow_out, pixel_write_address_out, pixel_write_data_out);
        end
        tick();
        rst_n = 1'b1;
        pixel_write_ready_in = 1'b1;
        repeat (4) tick();
        total++;
        if (en_cnt != 0 || wr_addr.size() != 0) begin
            bad++;
            $display("FAIL rst_abandon: enable_cycles=%0d writes=%0d want 0 0", en_cnt, wr_addr.size());
        end
    endtask

    initial begin
        rst_n                = 1'b0;
        op_code_in           = 8'h00;
        op_code_valid_in     = 1'b0;
        operand_in           = 8'h00;
        operand_valid_in     = 1'b0;
        operand_count_in     = 32'd0;
        pixel_write_ready_in = 1'b0;
        clear_obs();
        test_reset();
        test_assign();
        test_draw();
        test_fill_wrap();
        test_show();
        test_zero_len();
        test_back_to_back();
        test_random();
        test_reset_mid_span();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
